sram_scan_ctrl: RTL and testbench

Parametrised serial scan controller that drives OpenRAM macros from GPIO pins. It generalises the fixed 112-bit, 2-port, single-access scan chain. A packet is shifted in serially, then launched as one SRAM access or as an auto-incrementing burst. Read data is captured and can be scanned back out. An optional on-chip compare against the expected data field raises a sticky error flag.

---
 rtl/sram_scan_ctrl_if.sv | 52 +++++
 rtl/sram_scan_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_sram_scan_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_scan_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sram_scan_ctrl_if                                          |
// | Description : GPIO-side scan/launch pins and SRAM-side macro pins of the |
// |               serial scan controller, bundled for one connection.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface sram_scan_ctrl_if #(
  parameter int SEL_WIDTH   = 4,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_PORTS   = 2,
  parameter int BURST_WIDTH = 4
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  // Host (GPIO) side
  logic                             scan_en;
  logic                             scan_in;
  logic                             scan_out;
  logic                             global_csb;
  logic                             sram_load;
  logic [BURST_WIDTH-1:0]           burst_len;
  logic                             compare_en;
  logic                             busy;
  logic                             err;
  logic [ADDR_WIDTH-1:0]            err_addr;

  // Macro side; flattened vectors carry port 0 in the MSBs, csb/web index by port
  logic [SEL_WIDTH-1:0]             sram_sel;
  logic [NUM_PORTS-1:0]             sram_csb;
  logic [NUM_PORTS-1:0]             sram_web;
  logic [NUM_PORTS*ADDR_WIDTH-1:0]  sram_addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0]  sram_din;
  logic [NUM_PORTS*MASK_WIDTH-1:0]  sram_wmask;
  logic [NUM_PORTS*DATA_WIDTH-1:0]  sram_dout;

  // Pin driver / memory side
  modport master (
    output scan_en, scan_in, global_csb, sram_load, burst_len, compare_en, sram_dout,
    input  scan_out, busy, err, err_addr,
    input  sram_sel, sram_csb, sram_web, sram_addr, sram_din, sram_wmask
  );

  // Controller side
  modport slave (
    input  scan_en, scan_in, global_csb, sram_load, burst_len, compare_en, sram_dout,
    output scan_out, busy, err, err_addr,
    output sram_sel, sram_csb, sram_web, sram_addr, sram_din, sram_wmask
  );
endinterface
`default_nettype wire

// File: rtl/sram_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sram_scan_ctrl                                             |
// | Description : Serial scan controller for OpenRAM macros. A packet is     |
// |               shifted in, launched as a single access or an auto-        |
// |               incrementing burst, read data is captured, optionally      |
// |               compared against the packet, and can be scanned back out.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sram_scan_ctrl #(
  parameter int SEL_WIDTH    = 4,
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_PORTS    = 2,
  parameter int BURST_WIDTH  = 4,
  parameter int READ_LATENCY = 1
) (
  input wire              clk,
  input wire              reset_n,
  sram_scan_ctrl_if.slave bus
);

  localparam int MASK_WIDTH = DATA_WIDTH / 8;
  localparam int PORT_WIDTH = ADDR_WIDTH + DATA_WIDTH + 2 + MASK_WIDTH;
  localparam int SCAN_WIDTH = SEL_WIDTH + NUM_PORTS * PORT_WIDTH;
  // Field offsets inside one port slice: {addr, data, csb, web, wmask}
  localparam int WEB_BIT    = MASK_WIDTH;
  localparam int CSB_BIT    = MASK_WIDTH + 1;
  localparam int DATA_LSB   = MASK_WIDTH + 2;
  localparam int ADDR_LSB   = DATA_LSB + DATA_WIDTH;
  localparam logic [1:0] LAT_INIT = 2'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SHIFT  = 3'd1,
    S_ACCESS = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [SCAN_WIDTH-1:0]   chain_q;
  logic [DATA_WIDTH-1:0]   dout_q [NUM_PORTS];
  logic                    scan_out_q;
  logic                    csb_prev_q;
  logic                    err_q;
  logic [ADDR_WIDTH-1:0]   err_addr_q;
  logic [BURST_WIDTH-1:0]  cnt_q;
  logic [BURST_WIDTH-1:0]  idx_q;
  logic [1:0]              lat_q;

  logic                    do_shift, do_launch, do_load, do_capture;
  logic                    in_access;

  logic [ADDR_WIDTH-1:0]   port_addr  [NUM_PORTS];
  logic [ADDR_WIDTH-1:0]   acc_addr   [NUM_PORTS];
  logic [DATA_WIDTH-1:0]   port_data  [NUM_PORTS];
  logic [DATA_WIDTH-1:0]   rd_data    [NUM_PORTS];
  logic [MASK_WIDTH-1:0]   port_wmask [NUM_PORTS];
  logic [NUM_PORTS-1:0]    port_csb, port_web, cap_en, mismatch;
  logic [ADDR_WIDTH-1:0]   mm_addr;

  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_out;
  logic [NUM_PORTS*DATA_WIDTH-1:0] din_out;
  logic [NUM_PORTS*MASK_WIDTH-1:0] wmask_out;
  logic [NUM_PORTS-1:0]            csb_out, web_out;

  // Unpack each port slice of the chain; port 0 sits just below sel
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    localparam int BASE = (NUM_PORTS - 1 - p) * PORT_WIDTH;
    assign port_addr[p]  = chain_q[BASE + ADDR_LSB +: ADDR_WIDTH];
    assign port_data[p]  = chain_q[BASE + DATA_LSB +: DATA_WIDTH];
    assign port_csb[p]   = chain_q[BASE + CSB_BIT];
    assign port_web[p]   = chain_q[BASE + WEB_BIT];
    assign port_wmask[p] = chain_q[BASE +: MASK_WIDTH];
    assign acc_addr[p]   = port_addr[p] + ADDR_WIDTH'(idx_q);
    assign rd_data[p]    = bus.sram_dout[(NUM_PORTS - 1 - p) * DATA_WIDTH +: DATA_WIDTH];
    // Only enabled read ports return data worth capturing
    assign cap_en[p]     = ~port_csb[p] & port_web[p];
    assign mismatch[p]   = cap_en[p] & bus.compare_en & (rd_data[p] != port_data[p]);
  end

  assign in_access = (state_q == S_ACCESS);

  // Next-state decode and single-cycle control strobes for the datapath
  always_comb begin
    state_d    = state_q;
    do_shift   = 1'b0;
    do_launch  = 1'b0;
    do_load    = 1'b0;
    do_capture = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Shifting has priority over both launch and load
        if (bus.scan_en) begin
          do_shift = 1'b1;
          state_d  = S_SHIFT;
        end else if (csb_prev_q && !bus.global_csb) begin
          do_launch = 1'b1;
          state_d   = S_ACCESS;
        end else if (bus.sram_load) begin
          do_load = 1'b1;
        end
      end
      S_SHIFT: begin
        if (bus.scan_en) do_shift = 1'b1;
        else             state_d  = S_IDLE;
      end
      S_ACCESS: state_d = S_WAIT;
      S_WAIT: begin
        if (lat_q == 2'd0) begin
          do_capture = 1'b1;
          state_d    = (cnt_q == '0) ? S_DONE : S_ACCESS;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register; async reset aborts any burst and parks the macro
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Launch edge detector and registered serial output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csb_prev_q <= 1'b0;
      scan_out_q <= 1'b0;
    end else begin
      csb_prev_q <= bus.global_csb;
      scan_out_q <= chain_q[SCAN_WIDTH-1];
    end
  end

  // Scan chain: serial shift, or reload of data fields from captured reads
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain_q <= '0;
    end else if (do_shift) begin
      chain_q <= {chain_q[SCAN_WIDTH-2:0], bus.scan_in};
    end else if (do_load) begin
      for (int p = 0; p < NUM_PORTS; p++)
        chain_q[(NUM_PORTS - 1 - p) * PORT_WIDTH + DATA_LSB +: DATA_WIDTH] <= dout_q[p];
    end
  end

  // Burst counter, access index and read-latency timer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      idx_q <= '0;
      lat_q <= 2'd0;
    end else begin
      if (do_launch) begin
        cnt_q <= bus.burst_len;
        idx_q <= '0;
      end else if (do_capture && (cnt_q != '0)) begin
        cnt_q <= cnt_q - BURST_WIDTH'(1);
        idx_q <= idx_q + BURST_WIDTH'(1);
      end
      if (in_access)
        lat_q <= LAT_INIT;
      else if ((state_q == S_WAIT) && (lat_q != 2'd0))
        lat_q <= lat_q - 2'd1;
    end
  end

  // Capture read data for enabled read ports
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < NUM_PORTS; p++) dout_q[p] <= '0;
    end else if (do_capture) begin
      for (int p = 0; p < NUM_PORTS; p++)
        if (cap_en[p]) dout_q[p] <= rd_data[p];
    end
  end

  // Lowest-numbered mismatching port supplies the reported address
  always_comb begin
    mm_addr = '0;
    for (int p = NUM_PORTS - 1; p >= 0; p--)
      if (mismatch[p]) mm_addr = acc_addr[p];
  end

  // Sticky compare error; only the first failing address is kept
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else if (do_launch && !bus.compare_en) begin
      err_q <= 1'b0;
    end else if (do_capture && (|mismatch)) begin
      err_q <= 1'b1;
      if (!err_q) err_addr_q <= mm_addr;
    end
  end

  // Drive macro pins; strobes are only active during ACCESS
  always_comb begin
    addr_out  = '0;
    din_out   = '0;
    wmask_out = '0;
    csb_out   = '1;
    web_out   = '1;
    for (int p = 0; p < NUM_PORTS; p++) begin
      addr_out [(NUM_PORTS - 1 - p) * ADDR_WIDTH +: ADDR_WIDTH] = acc_addr[p];
      din_out  [(NUM_PORTS - 1 - p) * DATA_WIDTH +: DATA_WIDTH] = port_data[p];
      wmask_out[(NUM_PORTS - 1 - p) * MASK_WIDTH +: MASK_WIDTH] = port_wmask[p];
      if (in_access) begin
        csb_out[p] = port_csb[p];
        web_out[p] = port_web[p];
      end
    end
  end

  assign bus.sram_sel   = chain_q[SCAN_WIDTH-1 -: SEL_WIDTH];
  assign bus.sram_addr  = addr_out;
  assign bus.sram_din   = din_out;
  assign bus.sram_wmask = wmask_out;
  assign bus.sram_csb   = csb_out;
  assign bus.sram_web   = web_out;
  assign bus.scan_out   = scan_out_q;
  assign bus.busy       = (state_q == S_ACCESS) || (state_q == S_WAIT) || (state_q == S_DONE);
  assign bus.err        = err_q;
  assign bus.err_addr   = err_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sram_scan_ctrl                                          |
// | Description : Directed self-checking bench for sram_scan_ctrl with a     |
// |               behavioural two-port SRAM and a strobe monitor.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_sram_scan_ctrl;

  localparam int SEL_WIDTH    = 4;
  localparam int ADDR_WIDTH   = 16;
  localparam int DATA_WIDTH   = 32;
  localparam int NUM_PORTS    = 2;
  localparam int BURST_WIDTH  = 4;
  localparam int READ_LATENCY = 1;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   tests_run    = 0;
  int   tests_failed = 0;

  sram_scan_ctrl_if #(
    .SEL_WIDTH(SEL_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .NUM_PORTS(NUM_PORTS), .BURST_WIDTH(BURST_WIDTH)
  ) bus ();

  sram_scan_ctrl #(
    .SEL_WIDTH(SEL_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .NUM_PORTS(NUM_PORTS), .BURST_WIDTH(BURST_WIDTH), .READ_LATENCY(READ_LATENCY)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM, one-cycle read latency, full-word writes
  logic [31:0] mem [logic [15:0]];
  logic [31:0] mdout0 = '0;
  logic [31:0] mdout1 = '0;
  bit          corrupt_en   = 1'b0;
  logic [15:0] corrupt_addr = '0;
  assign bus.sram_dout = {mdout0, mdout1};

  function automatic logic [31:0] mem_rd(input logic [15:0] a);
    logic [31:0] v;
    v = mem.exists(a) ? mem[a] : 32'h0;
    if (corrupt_en && (a == corrupt_addr)) v = v ^ 32'h1;
    return v;
  endfunction

  always @(posedge clk) begin
    if (bus.sram_csb[0] === 1'b0) begin
      if (bus.sram_web[0] === 1'b0) mem[bus.sram_addr[31:16]] = bus.sram_din[63:32];
      else                          mdout0 <= mem_rd(bus.sram_addr[31:16]);
    end
    if (bus.sram_csb[1] === 1'b0) begin
      if (bus.sram_web[1] === 1'b0) mem[bus.sram_addr[15:0]] = bus.sram_din[31:0];
      else                          mdout1 <= mem_rd(bus.sram_addr[15:0]);
    end
  end

  // Strobe monitor: one entry per cycle with any chip select low
  typedef struct {
    logic [15:0] a0;
    logic [31:0] d0;
    logic [3:0]  sel;
    logic [1:0]  csb;
    logic [1:0]  web;
    logic        err;
  } strobe_t;
  strobe_t strobes[$];

  always @(negedge clk) begin
    strobe_t s;
    if (bus.sram_csb !== 2'b11) begin
      s.a0  = bus.sram_addr[31:16];
      s.d0  = bus.sram_din[63:32];
      s.sel = bus.sram_sel;
      s.csb = bus.sram_csb;
      s.web = bus.sram_web;
      s.err = bus.err;
      strobes.push_back(s);
    end
  end

  function automatic logic [111:0] pkt(
    input logic [3:0] sel,
    input logic [15:0] a0, input logic [31:0] d0, input logic c0, input logic w0, input logic [3:0] m0,
    input logic [15:0] a1, input logic [31:0] d1, input logic c1, input logic w1, input logic [3:0] m1);
    return {sel, a0, d0, c0, w0, m0, a1, d1, c1, w1, m1};
  endfunction

  task automatic shift_in(input logic [111:0] p);
    for (int i = 111; i >= 0; i--) begin
      bus.scan_en = 1'b1;
      bus.scan_in = p[i];
      @(negedge clk);
    end
    bus.scan_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic shift_out(output logic [111:0] got);
    for (int i = 0; i < 112; i++) begin
      bus.scan_en = 1'b1;
      bus.scan_in = 1'b0;
      @(negedge clk);
      got[111-i] = bus.scan_out;
    end
    bus.scan_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_load();
    bus.sram_load = 1'b1;
    @(negedge clk);
    bus.sram_load = 1'b0;
  endtask

  // Drop global_csb and count busy cycles; the bound turns a hang into a count mismatch
  task automatic do_launch(input logic [3:0] bl, input logic cmp, output int busy_cycles);
    bus.burst_len  = bl;
    bus.compare_en = cmp;
    bus.global_csb = 1'b0;
    busy_cycles = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) busy_cycles++;
      else break;
    end
    bus.global_csb = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.sram_csb !== 2'b11) begin tests_failed++; $display("FAIL reset_csb: got %b want 11", bus.sram_csb); end
    tests_run++;
    if (bus.sram_web !== 2'b11) begin tests_failed++; $display("FAIL reset_web: got %b want 11", bus.sram_web); end
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    tests_run++;
    if (bus.err !== 1'b0 || bus.err_addr !== 16'h0) begin
      tests_failed++; $display("FAIL reset_err: got err=%b addr=%h want 0/0000", bus.err, bus.err_addr);
    end
    tests_run++;
    if (bus.scan_out !== 1'b0 || bus.sram_addr !== 32'h0 || bus.sram_sel !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_chain: got so=%b addr=%h sel=%h want 0", bus.scan_out, bus.sram_addr, bus.sram_sel);
    end
    reset_n = 1'b1;
    @(negedge clk);
    strobes.delete();
  endtask

  task automatic test_single_write();
    int bc;
    shift_in(pkt(4'd2, 16'd1, 32'h2, 1'b0, 1'b0, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'h0));
    strobes.delete();
    do_launch(4'd0, 1'b0, bc);
    tests_run++;
    if (strobes.size() != 1) begin tests_failed++; $display("FAIL single_count: got %0d want 1", strobes.size()); end
    if (strobes.size() >= 1) begin
      tests_run++;
      if (strobes[0].csb !== 2'b10 || strobes[0].web[0] !== 1'b0) begin
        tests_failed++; $display("FAIL single_csb: got csb=%b web=%b want 10/x0", strobes[0].csb, strobes[0].web);
      end
      tests_run++;
      if (strobes[0].a0 !== 16'd1 || strobes[0].d0 !== 32'h2 || strobes[0].sel !== 4'd2) begin
        tests_failed++;
        $display("FAIL single_fields: got a=%h d=%h sel=%h want 0001/00000002/2", strobes[0].a0, strobes[0].d0, strobes[0].sel);
      end
    end
    tests_run++;
    if (bc != 3) begin tests_failed++; $display("FAIL single_busy: got %0d want 3", bc); end
    tests_run++;
    if (mem_rd(16'd1) !== 32'h2) begin tests_failed++; $display("FAIL single_mem: got %h want 2", mem_rd(16'd1)); end
  endtask

  task automatic test_read_load();
    int bc;
    logic [111:0] got, expv;
    shift_in(pkt(4'd0, 16'd1, 32'hA, 1'b0, 1'b0, 4'hF, 16'd2, 32'h50, 1'b0, 1'b0, 4'hF));
    strobes.delete();
    do_launch(4'd0, 1'b0, bc);
    tests_run++;
    if (strobes.size() != 1 || strobes[0].csb !== 2'b00) begin
      tests_failed++; $display("FAIL dual_write: got n=%0d want one strobe with csb 00", strobes.size());
    end
    shift_in(pkt(4'd0, 16'd1, 32'h0, 1'b0, 1'b1, 4'hF, 16'd2, 32'h0, 1'b0, 1'b1, 4'hF));
    do_launch(4'd0, 1'b0, bc);
    pulse_load();
    shift_out(got);
    expv = pkt(4'd0, 16'd1, 32'hA, 1'b0, 1'b1, 4'hF, 16'd2, 32'h50, 1'b0, 1'b1, 4'hF);
    tests_run++;
    if (got !== expv) begin tests_failed++; $display("FAIL read_load_scan: got %h want %h", got, expv); end
  endtask

  task automatic test_burst_wrap();
    int bc;
    logic [15:0] exp_a [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    shift_in(pkt(4'd1, 16'hFFFE, 32'hDEADBEEF, 1'b0, 1'b0, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'h0));
    strobes.delete();
    do_launch(4'd3, 1'b0, bc);
    tests_run++;
    if (strobes.size() != 4) begin tests_failed++; $display("FAIL burst_count: got %0d want 4", strobes.size()); end
    for (int i = 0; i < 4 && i < strobes.size(); i++) begin
      tests_run++;
      if (strobes[i].a0 !== exp_a[i] || strobes[i].csb !== 2'b10) begin
        tests_failed++;
        $display("FAIL burst_addr%0d: got a=%h csb=%b want %h/10", i, strobes[i].a0, strobes[i].csb, exp_a[i]);
      end
    end
    tests_run++;
    if (bc != 9 || bus.busy !== 1'b0) begin
      tests_failed++; $display("FAIL burst_busy: got %0d busy=%b want 9/0", bc, bus.busy);
    end
  endtask

  task automatic test_burst_compare();
    int bc;
    shift_in(pkt(4'd0, 16'hFFFF, 32'hDEADBEEF, 1'b0, 1'b1, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'h0));
    corrupt_en   = 1'b1;
    corrupt_addr = 16'h0001;
    strobes.delete();
    do_launch(4'd2, 1'b1, bc);
    corrupt_en = 1'b0;
    tests_run++;
    if (strobes.size() != 3 || bc != 7) begin
      tests_failed++; $display("FAIL cmp_count: got n=%0d busy=%0d want 3/7", strobes.size(), bc);
    end
    if (strobes.size() == 3) begin
      tests_run++;
      if (strobes[1].err !== 1'b0 || strobes[2].err !== 1'b0 || strobes[2].a0 !== 16'h0001) begin
        tests_failed++;
        $display("FAIL cmp_early_err: got err1=%b err2=%b a2=%h want 0/0/0001", strobes[1].err, strobes[2].err, strobes[2].a0);
      end
    end
    tests_run++;
    if (bus.err !== 1'b1 || bus.err_addr !== 16'h0001) begin
      tests_failed++; $display("FAIL cmp_err: got err=%b addr=%h want 1/0001", bus.err, bus.err_addr);
    end
    shift_in(pkt(4'd0, 16'hFFFE, 32'hDEADBEEF, 1'b0, 1'b1, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'h0));
    do_launch(4'd0, 1'b1, bc);
    tests_run++;
    if (bus.err !== 1'b1 || bus.err_addr !== 16'h0001) begin
      tests_failed++; $display("FAIL cmp_sticky: got err=%b addr=%h want 1/0001", bus.err, bus.err_addr);
    end
    do_launch(4'd0, 1'b0, bc);
    tests_run++;
    if (bus.err !== 1'b0) begin tests_failed++; $display("FAIL cmp_clear: got err=%b want 0", bus.err); end
  endtask

  task automatic test_scan_priority();
    logic [111:0] p5, got, expv;
    p5 = pkt(4'h5, 16'h1234, 32'h0, 1'b0, 1'b1, 4'hF, 16'h4321, 32'h0, 1'b0, 1'b1, 4'h3);
    shift_in(p5);
    strobes.delete();
    bus.scan_en    = 1'b1;
    bus.scan_in    = 1'b1;
    bus.global_csb = 1'b0;
    bus.sram_load  = 1'b1;
    @(negedge clk);
    bus.scan_en    = 1'b0;
    bus.sram_load  = 1'b0;
    bus.global_csb = 1'b1;
    repeat (4) @(negedge clk);
    tests_run++;
    if (strobes.size() != 0 || bus.busy !== 1'b0) begin
      tests_failed++; $display("FAIL prio_no_launch: got strobes=%0d busy=%b want 0/0", strobes.size(), bus.busy);
    end
    // Chain shifted by one; data fields then replaced by the untouched dout registers
    expv = {p5[110:0], 1'b1};
    expv[91:60] = 32'hDEADBEEF;
    expv[37:6]  = 32'h00000050;
    pulse_load();
    shift_out(got);
    tests_run++;
    if (got !== expv) begin tests_failed++; $display("FAIL prio_chain: got %h want %h", got, expv); end
  endtask

  task automatic test_reset_midburst();
    shift_in(pkt(4'h1, 16'h0100, 32'h11111111, 1'b0, 1'b1, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'h0));
    strobes.delete();
    bus.burst_len  = 4'd7;
    bus.compare_en = 1'b1;
    bus.global_csb = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.sram_csb !== 2'b10 || bus.err !== 1'b1 || bus.sram_addr[31:16] !== 16'h0101) begin
      tests_failed++;
      $display("FAIL mid_second_access: got csb=%b err=%b a=%h want 10/1/0101", bus.sram_csb, bus.err, bus.sram_addr[31:16]);
    end
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if (bus.sram_csb !== 2'b11 || bus.busy !== 1'b0) begin
      tests_failed++; $display("FAIL mid_abort: got csb=%b busy=%b want 11/0", bus.sram_csb, bus.busy);
    end
    tests_run++;
    if (bus.err !== 1'b0 || bus.err_addr !== 16'h0) begin
      tests_failed++; $display("FAIL mid_err_clear: got err=%b addr=%h want 0/0000", bus.err, bus.err_addr);
    end
    bus.global_csb = 1'b1;
    bus.compare_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    test_single_write();
  endtask

  initial begin
    bus.scan_en    = 1'b0;
    bus.scan_in    = 1'b0;
    bus.global_csb = 1'b1;
    bus.sram_load  = 1'b0;
    bus.burst_len  = '0;
    bus.compare_en = 1'b0;
    test_reset();
    test_single_write();
    test_read_load();
    test_burst_wrap();
    test_burst_compare();
    test_scan_priority();
    test_reset_midburst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
